load_store_ctrl: RTL and testbench
==================================

// Module: load_store_ctrl
// PURPOSE
//  Sequences sub-word loads/stores between the pipeline MEM stage and a word-wide data memory.
//  - Memory has no byte enables, so SH/SB run as read-modify-write.
//  - Loads are sign/zero-extended here.
//  - One request is in flight at a time; the MEM stage stalls while req_ready=0.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles mem_req may stay high without mem_ack before the access aborts (>=1)
// PORTS
//  Clk         in   1   clock, rising edge
//  Rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present; accepted when req_valid & req_ready
//  req_ready   out  1   high only in IDLE
//  req_op      in   3   000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU, 101 SW, 110 SH, 111 SB
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; SH uses [15:0], SB uses [7:0]
//  resp_valid  out  1   one-cycle completion pulse; no backpressure
//  resp_rdata  out  32  extended load data; 0 for stores and on error
//  resp_err    out  1   valid with resp_valid: timeout, or misaligned access (macro only)
//  mem_req     out  1   memory request, held until mem_ack
//  mem_we      out  1   1 = write, 0 = read; stable while mem_req is high
//  mem_addr    out  32  word address; bits [1:0] always 0
//  mem_wdata   out  32  full write word
//  mem_rdata   in   32  read data, valid in the mem_ack cycle
//  mem_ack     in   1   one-cycle completion; ignored while mem_req=0
// BEHAVIOUR
//  Reset (async, on Rst_n low, any state):
//  - State -> IDLE; all outputs and registers cleared; req_ready=1 after release.
//  - An in-flight transaction is abandoned with no response.
//  States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
//  - IDLE on accept: latch op/addr/wdata, then:
//    - loads -> RD; SW -> WR; SH/SB -> RMW_RD.
//  - mem_req/mem_we/mem_addr/mem_wdata are registered; mem_req rises the cycle after accept.
//  - RD / WR: on mem_ack, drop mem_req and go to RESP.
//  - RMW_RD: on mem_ack, merge new lane(s) into mem_rdata; next cycle is RMW_WR with mem_we=1.
//  - RMW_WR: on mem_ack, go to RESP.
//  - RESP: resp_valid=1 for one cycle, then IDLE.
//    - req_ready is low in RESP; the next request is accepted in the following cycle.
//  Lanes (little-endian):
//  - byte k = word[8k+7:8k], k = addr[1:0].
//  - halfword = word[31:16] if addr[1]=1, else word[15:0].
//  - LH/LB sign-extend; LHU/LBU zero-extend; LW passes the word unchanged.
//  Latency with ack N cycles after mem_req rises (N>=1): resp_valid rises N+1 cycles after mem_req.
//  - Loads and SW: accept at t0, resp_valid at t0+N+2.
//  - RMW: two memory phases, one idle cycle between them (mem_req low).
//  Timeout:
//  - A counter resets at every mem_req rise and counts cycles with mem_req=1 & mem_ack=0.
//  - Reaching TIMEOUT_CYCLES: drop mem_req and go to RESP with resp_err=1, resp_rdata=0.
//  - A timeout in RMW_RD skips the write.
//  - An ack in the same cycle as the timeout wins; the access completes normally.
//  busy-free guarantee: mem_we, mem_addr and mem_wdata never change while mem_req=1.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//  - Misaligned access (word with addr[1:0]!=0, half with addr[0]=1) raises no mem_req.
//  - IDLE goes to RESP; resp_valid and resp_err=1 arrive two cycles after accept.
//  MISALIGN_TRAP_EN undefined:
//  - Offending low address bits are treated as 0 (word -> [1:0]=0, half -> [0]=0).
//  - The access proceeds normally; resp_err is set only on timeout.
// TESTING
//  1. LB @0x103, mem word 0x80FF1234, ack N=1 -> mem_addr 0x100; resp_rdata 0xFFFFFF80, err 0, at t0+3.
//  2. LBU @0x103, same word -> resp_rdata 0x00000080; LHU @0x102 -> 0x000080FF.
//  3. SH @0x102 wdata 0xXXXXABCD, old word 0x11223344:
//     - read then write 0xABCD3344 @0x100; resp_rdata 0; err 0.
//  4. TIMEOUT_CYCLES=4, LW with no ack:
//     - mem_req high exactly 4 cycles, then resp_valid with err=1, rdata=0.
//  5. Rst_n low during RMW_WR with mem_req=1:
//     - mem_req=0 immediately; no resp_valid; next SB completes normally.
//  6. LW @0x101:
//     - with MISALIGN_TRAP_EN: no mem_req; err=1 at t0+2.
//     - without: reads @0x100, err=0.

Source files
------------

// File: rtl/load_store_ctrl.sv
// load_store_ctrl: sequences MEM-stage loads/stores against a word-wide data memory with no byte enables.
// Latency: accept at t0, response at t0+N+2 (loads/SW) or t0+N1+N2+4 (SH/SB read-modify-write), N = ack delay.
// Backpressure: one access in flight; req_ready is high only in IDLE; resp_valid is a one-cycle pulse, never stalled.
//
// Ports:
//   Clk, Rst_n                    clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_op/req_addr/req_wdata latched on accept
//   resp_valid/resp_rdata/resp_err one-cycle completion: extended load data, error on timeout or trap
//   mem_req/mem_we/mem_addr/mem_wdata  registered word-wide memory request, held until mem_ack
//   mem_rdata/mem_ack             memory read data and one-cycle completion strobe
//
// Build option: define MISALIGN_TRAP_EN to answer misaligned word/half accesses with resp_err
// instead of silently clearing the offending low address bits.
module load_store_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  // The counter only has to hold 0..TIMEOUT_CYCLES-1.
  localparam int CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] opLw  = 3'b000;
  localparam logic [2:0] opLh  = 3'b001;
  localparam logic [2:0] opLb  = 3'b010;
  localparam logic [2:0] opLhu = 3'b011;
  localparam logic [2:0] opLbu = 3'b100;
  localparam logic [2:0] opSw  = 3'b101;
  localparam logic [2:0] opSh  = 3'b110;
  localparam logic [2:0] opSb  = 3'b111;

  // sTrap is only reachable with MISALIGN_TRAP_EN; it provides the single
  // dead cycle between accept and the error response.
  typedef enum logic [2:0] {
    sIdle  = 3'd0,
    sRd    = 3'd1,
    sWr    = 3'd2,
    sRmwRd = 3'd3,
    sRmwWr = 3'd4,
    sResp  = 3'd5,
    sTrap  = 3'd6
  } state_t;

  state_t stateQ, stateD;

  // Latched request: only the lane-select bits and the sub-word store data
  // are needed after accept; the word address and SW data go straight into
  // the memory request registers.
  logic [2:0]  opQ;
  logic [1:0]  addrLowQ;
  logic [15:0] wdataLowQ;

  logic            memReqQ;
  logic            memWeQ;
  logic [31:0]     memAddrQ;
  logic [31:0]     memWdataQ;
  logic [CntW-1:0] toCntQ;
  logic [31:0]     respRdataQ;
  logic            respErrQ;

  logic        ackSeen;
  logic        timeoutHit;
  logic [15:0] halfLane;
  logic [7:0]  byteLane;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  assign ackSeen = memReqQ && mem_ack;
  // An ack in the same cycle always wins over the timeout.
  assign timeoutHit = memReqQ && !mem_ack && (toCntQ == CntW'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  logic reqMisaligned;

  always_comb begin
    reqMisaligned = 1'b0;
    case (req_op)
      opLw, opSw:        reqMisaligned = (req_addr[1:0] != 2'b00);
      opLh, opLhu, opSh: reqMisaligned = req_addr[0];
      default:           reqMisaligned = 1'b0;
    endcase
  end
`endif

  // Lane extraction for loads. Without the trap option a misaligned word or
  // half access behaves as aligned simply because the word address drops
  // [1:0] and the half lane looks only at addr[1].
  always_comb begin
    halfLane = addrLowQ[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (addrLowQ)
      2'd0:    byteLane = mem_rdata[7:0];
      2'd1:    byteLane = mem_rdata[15:8];
      2'd2:    byteLane = mem_rdata[23:16];
      default: byteLane = mem_rdata[31:24];
    endcase
    case (opQ)
      opLh:    loadData = {{16{halfLane[15]}}, halfLane};
      opLb:    loadData = {{24{byteLane[7]}}, byteLane};
      opLhu:   loadData = {16'h0000, halfLane};
      opLbu:   loadData = {24'h000000, byteLane};
      default: loadData = mem_rdata;
    endcase
  end

  // Merge the store lane into the word returned by the RMW read phase.
  always_comb begin
    mergedWord = mem_rdata;
    if (opQ == opSh) begin
      if (addrLowQ[1]) mergedWord[31:16] = wdataLowQ;
      else             mergedWord[15:0]  = wdataLowQ;
    end else begin
      case (addrLowQ)
        2'd0:    mergedWord[7:0]   = wdataLowQ[7:0];
        2'd1:    mergedWord[15:8]  = wdataLowQ[7:0];
        2'd2:    mergedWord[23:16] = wdataLowQ[7:0];
        default: mergedWord[31:24] = wdataLowQ[7:0];
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) stateQ <= sIdle;
    else        stateQ <= stateD;
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      sIdle: begin
        if (req_valid) begin
          if (req_op <= opLbu)    stateD = sRd;
          else if (req_op == opSw) stateD = sWr;
          else                     stateD = sRmwRd;
`ifdef MISALIGN_TRAP_EN
          if (reqMisaligned) stateD = sTrap;
`endif
        end
      end
      sRd, sWr: begin
        if (ackSeen || timeoutHit) stateD = sResp;
      end
      sRmwRd: begin
        // A timeout here abandons the write phase altogether.
        if (ackSeen)         stateD = sRmwWr;
        else if (timeoutHit) stateD = sResp;
      end
      sRmwWr: begin
        // First cycle here has mem_req low; ackSeen masks any stray ack.
        if (ackSeen || timeoutHit) stateD = sResp;
      end
      sTrap:   stateD = sResp;
      sResp:   stateD = sIdle;
      default: stateD = sIdle;
    endcase
  end

  // Datapath: request latch, registered memory interface, timeout counter
  // and response data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      opQ        <= 3'b000;
      addrLowQ   <= 2'b00;
      wdataLowQ  <= 16'h0000;
      memReqQ    <= 1'b0;
      memWeQ     <= 1'b0;
      memAddrQ   <= 32'h0000_0000;
      memWdataQ  <= 32'h0000_0000;
      toCntQ     <= '0;
      respRdataQ <= 32'h0000_0000;
      respErrQ   <= 1'b0;
    end else begin
      case (stateQ)
        sIdle: begin
          if (req_valid) begin
            opQ        <= req_op;
            addrLowQ   <= req_addr[1:0];
            wdataLowQ  <= req_wdata[15:0];
            memAddrQ   <= {req_addr[31:2], 2'b00};
            memWeQ     <= (req_op == opSw);
            memWdataQ  <= req_wdata;
            toCntQ     <= '0;
            respRdataQ <= 32'h0000_0000;
            respErrQ   <= 1'b0;
            memReqQ    <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (reqMisaligned) begin
              memReqQ  <= 1'b0;
              respErrQ <= 1'b1;
            end
`endif
          end
        end
        sRd, sWr, sRmwRd, sRmwWr: begin
          if (!memReqQ) begin
            // Idle cycle between the RMW phases: launch the write.
            memReqQ <= 1'b1;
            toCntQ  <= '0;
          end else if (mem_ack) begin
            memReqQ <= 1'b0;
            if (stateQ == sRd) respRdataQ <= loadData;
            if (stateQ == sRmwRd) begin
              memWeQ    <= 1'b1;
              memWdataQ <= mergedWord;
            end
          end else if (timeoutHit) begin
            memReqQ  <= 1'b0;
            respErrQ <= 1'b1;
          end else begin
            toCntQ <= toCntQ + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    req_ready  = (stateQ == sIdle);
    resp_valid = (stateQ == sResp);
    resp_rdata = (stateQ == sResp) ? respRdataQ : 32'h0000_0000;
    resp_err   = (stateQ == sResp) && respErrQ;
    mem_req    = memReqQ;
    mem_we     = memWeQ;
    mem_addr   = memAddrQ;
    mem_wdata  = memWdataQ;
  end

  // Unused-op guard: opSh/opSb are decoded by elimination above.
  logic unusedOps;
  assign unusedOps = (opQ == opSb);

endmodule

// File: tb/tb_load_store_ctrl.sv
module tb_load_store_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Environment memory (what the DUT really wrote) and reference memory
  // (what the ISA semantics say it should hold). Window 0x100..0x13F.
  logic [31:0] envMem [16];
  logic [31:0] refMem [16];
  int rdDly = 1;
  int wrDly = 1;
  int riseCnt = 0;
  int wrCnt = 0;
  int lastLen = 0;
  logic [31:0] lastRdAddr = 32'h0;
  logic [31:0] lastWrAddr = 32'h0;
  int respCnt = 0;
  int stableViol = 0;

  load_store_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // Memory responder: ack arrives N cycles after mem_req rises (N = rdDly or wrDly).
  initial begin
    int k;
    logic seen;
    int curLen;
    k = 0; seen = 1'b0; curLen = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge Clk);
      #1;
      if (mem_req) begin
        if (!seen) begin k = 0; curLen = 0; riseCnt++; end
        else k++;
        seen = 1'b1;
        curLen++;
        if (k == (mem_we ? wrDly : rdDly)) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            envMem[mem_addr[5:2]] = mem_wdata;
            wrCnt++;
            lastWrAddr = mem_addr;
          end else begin
            mem_rdata = envMem[mem_addr[5:2]];
            lastRdAddr = mem_addr;
          end
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (seen) lastLen = curLen;
        seen = 1'b0;
        mem_ack = 1'b0;
      end
    end
  end

  // Passive monitors: response pulses and memory-request stability.
  logic pReq = 1'b0;
  logic pWe = 1'b0;
  logic [31:0] pAddr = 32'h0;
  logic [31:0] pWd = 32'h0;
  always @(negedge Clk) begin
    if (resp_valid) respCnt++;
    if (mem_req && pReq && (mem_we !== pWe || mem_addr !== pAddr || mem_wdata !== pWd)) stableViol++;
    if (mem_req && mem_addr[1:0] != 2'b00) stableViol++;
    pReq = mem_req; pWe = mem_we; pAddr = mem_addr; pWd = mem_wdata;
  end

  // Reference semantics.
  function automatic logic [31:0] refLoad(input logic [2:0] op, input logic [31:0] addr,
                                          input logic [31:0] word);
    int unsigned bsh, hsh;
    logic [31:0] b, h;
    bsh = 8 * addr[1:0];
    hsh = 16 * addr[1];
    b = (word >> bsh) & 32'h0000_00FF;
    h = (word >> hsh) & 32'h0000_FFFF;
    case (op)
      3'd0: return word;
      3'd1: return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
      3'd2: return (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
      3'd3: return h;
      3'd4: return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] refStore(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] old, input logic [31:0] wd);
    int unsigned bsh, hsh;
    logic [31:0] mask;
    bsh = 8 * addr[1:0];
    hsh = 16 * addr[1];
    case (op)
      3'd5: return wd;
      3'd6: begin
        mask = 32'h0000_FFFF << hsh;
        return (old & ~mask) | ((wd & 32'h0000_FFFF) << hsh);
      end
      3'd7: begin
        mask = 32'h0000_00FF << bsh;
        return (old & ~mask) | ((wd & 32'h0000_00FF) << bsh);
      end
      default: return old;
    endcase
  endfunction

  function automatic logic refMisal(input logic [2:0] op, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
    if ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00) return 1'b1;
    if ((op == 3'd1 || op == 3'd3 || op == 3'd6) && addr[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Drives one request from a negedge, returns observations; ends on the
  // negedge after the response cycle (where the next request may start).
  task automatic doTxn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input int rd, input int wr,
                       output logic [31:0] rdata, output logic err, output int lat,
                       output logic rdyResp, output logic pulseOne, output int tAcc);
    int w;
    rdDly = rd; wrDly = wr;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge Clk); w++; end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    tAcc = cyc;
    @(negedge Clk);
    req_valid = 1'b0;
    lat = -1; rdata = 'x; err = 1'bx; rdyResp = 1'bx; pulseOne = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid) begin
        lat = cyc - tAcc; rdata = resp_rdata; err = resp_err; rdyResp = req_ready;
        break;
      end
      @(negedge Clk);
    end
    @(negedge Clk);
    pulseOne = !resp_valid;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) begin
      envMem[i] = $urandom;
      refMem[i] = envMem[i];
    end
    Rst_n = 1'b0;
    repeat (3) @(negedge Clk);
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_memctl got req=%b we=%b exp 0/0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_membus got addr=%h wdata=%h exp 0/0", mem_addr, mem_wdata); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0", resp_valid, resp_err, resp_rdata); end
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_idle_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_directed;
    logic [31:0] d; logic e, rr, p; int lat, t, r0, w0;
    envMem[0] = 32'h80FF1234; refMem[0] = 32'h80FF1234;
    doTxn(3'b010, 32'h103, 32'h0, 1, 1, d, e, lat, rr, p, t);
    checks++; if (lat !== 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", lat); end
    checks++; if (d !== 32'hFFFFFF80 || e !== 1'b0) begin failures++; $display("FAIL lb_data got=%h err=%b exp=ffffff80 err=0", d, e); end
    checks++; if (lastRdAddr !== 32'h100) begin failures++; $display("FAIL lb_memaddr got=%h exp=100", lastRdAddr); end
    checks++; if (rr !== 1'b0 || p !== 1'b1) begin failures++; $display("FAIL resp_shape got ready=%b onecycle=%b exp 0/1", rr, p); end
    doTxn(3'b100, 32'h103, 32'h0, 1, 1, d, e, lat, rr, p, t);
    checks++; if (d !== 32'h00000080 || e !== 1'b0) begin failures++; $display("FAIL lbu_data got=%h exp=00000080", d); end
    doTxn(3'b011, 32'h102, 32'h0, 2, 1, d, e, lat, rr, p, t);
    checks++; if (d !== 32'h000080FF || lat !== 4) begin failures++; $display("FAIL lhu_data got=%h lat=%0d exp=000080ff lat=4", d, lat); end
    envMem[0] = 32'h11223344; refMem[0] = 32'h11223344;
    doTxn(3'b110, 32'h102, 32'h5555ABCD, 1, 1, d, e, lat, rr, p, t);
    checks++; if (envMem[0] !== 32'hABCD3344 || lastWrAddr !== 32'h100) begin failures++; $display("FAIL sh_rmw got=%h @%h exp=abcd3344 @100", envMem[0], lastWrAddr); end
    checks++; if (d !== 32'h0 || e !== 1'b0 || lat !== 6) begin failures++; $display("FAIL sh_resp got d=%h e=%b lat=%0d exp 0/0/6", d, e, lat); end
    refMem[0] = 32'hABCD3344;
    r0 = riseCnt; w0 = wrCnt;
    doTxn(3'b000, 32'h101, 32'h0, 1, 1, d, e, lat, rr, p, t);
`ifdef MISALIGN_TRAP_EN
    checks++; if (e !== 1'b1 || lat !== 2 || d !== 32'h0) begin failures++; $display("FAIL lw_misal got e=%b lat=%0d d=%h exp 1/2/0", e, lat, d); end
    checks++; if (riseCnt !== r0) begin failures++; $display("FAIL lw_misal_noreq got rises=%0d exp=%0d", riseCnt, r0); end
`else
    checks++; if (e !== 1'b0 || lat !== 3 || d !== 32'hABCD3344) begin failures++; $display("FAIL lw_misal got e=%b lat=%0d d=%h exp 0/3/abcd3344", e, lat, d); end
    checks++; if (lastRdAddr !== 32'h100 || wrCnt !== w0) begin failures++; $display("FAIL lw_misal_addr got=%h exp=100", lastRdAddr); end
`endif
  endtask

  task automatic test_timeout;
    logic [31:0] d; logic e, rr, p; int lat, t, w0;
    doTxn(3'b000, 32'h104, 32'h0, 1000, 1, d, e, lat, rr, p, t);
    checks++; if (e !== 1'b1 || d !== 32'h0 || lat !== 5) begin failures++; $display("FAIL to_lw got e=%b d=%h lat=%0d exp 1/0/5", e, d, lat); end
    checks++; if (lastLen !== 4) begin failures++; $display("FAIL to_reqlen got=%0d exp=4", lastLen); end
    doTxn(3'b000, 32'h104, 32'h0, 3, 1, d, e, lat, rr, p, t);
    checks++; if (e !== 1'b0 || d !== refMem[1] || lat !== 5) begin failures++; $display("FAIL to_ackwins got e=%b d=%h lat=%0d exp 0/%h/5", e, d, lat, refMem[1]); end
    doTxn(3'b000, 32'h104, 32'h0, 4, 1, d, e, lat, rr, p, t);
    checks++; if (e !== 1'b1 || lat !== 5) begin failures++; $display("FAIL to_latack got e=%b lat=%0d exp 1/5", e, lat); end
    w0 = wrCnt;
    doTxn(3'b111, 32'h109, 32'hEE, 1000, 1, d, e, lat, rr, p, t);
    checks++; if (e !== 1'b1 || lat !== 5 || wrCnt !== w0) begin failures++; $display("FAIL to_rmwrd got e=%b lat=%0d writes=%0d exp 1/5/%0d", e, lat, wrCnt, w0); end
    doTxn(3'b111, 32'h109, 32'hEE, 1, 1000, d, e, lat, rr, p, t);
    checks++; if (e !== 1'b1 || lat !== 8 || envMem[2] !== refMem[2]) begin failures++; $display("FAIL to_rmwwr got e=%b lat=%0d mem=%h exp 1/8/%h", e, lat, envMem[2], refMem[2]); end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] d, expW; logic e, rr, p; int lat, t, w, r0;
    rdDly = 1; wrDly = 1000;
    req_valid = 1'b1; req_op = 3'b111; req_addr = 32'h105; req_wdata = 32'h77;
    @(negedge Clk);
    req_valid = 1'b0;
    w = 0;
    while (!(mem_req && mem_we) && w < 30) begin @(negedge Clk); w++; end
    checks++; if (w >= 30) begin failures++; $display("FAIL rst_reach_rmwwr got waited=%0d exp <30", w); end
    r0 = respCnt;
    Rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_async_req got=%b exp=0", mem_req); end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
    checks++; if (respCnt !== r0 || envMem[1] !== refMem[1]) begin failures++; $display("FAIL rst_noresp got resps=%0d mem=%h exp %0d/%h", respCnt, envMem[1], r0, refMem[1]); end
    expW = refStore(3'b111, 32'h105, refMem[1], 32'h77);
    doTxn(3'b111, 32'h105, 32'h77, 1, 1, d, e, lat, rr, p, t);
    checks++; if (envMem[1] !== expW || e !== 1'b0 || lat !== 6) begin failures++; $display("FAIL rst_next_sb got mem=%h e=%b lat=%0d exp %h/0/6", envMem[1], e, lat, expW); end
    refMem[1] = expW;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1, d2; logic e1, e2, rr, p; int l1, l2, t1, t2;
    doTxn(3'b000, 32'h10C, 32'h0, 2, 1, d1, e1, l1, rr, p, t1);
    doTxn(3'b001, 32'h10E, 32'h0, 1, 1, d2, e2, l2, rr, p, t2);
    checks++; if (t2 !== t1 + l1 + 1) begin failures++; $display("FAIL b2b_accept got=%0d exp=%0d", t2, t1 + l1 + 1); end
    checks++; if (d1 !== refMem[3] || d2 !== refLoad(3'b001, 32'h10E, refMem[3]) || l2 !== 3) begin failures++; $display("FAIL b2b_data got=%h %h lat=%0d", d1, d2, l2); end
  endtask

  task automatic test_random;
    logic [31:0] d, addr, wd, expD; logic e, rr, p, expE; int lat, t, rd, wr, expL, idx;
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      addr = 32'h100 + $urandom_range(0, 63);
      wd = $urandom;
      rd = $urandom_range(1, 3);
      wr = $urandom_range(1, 3);
      idx = int'(addr[5:2]);
      doTxn(op, addr, wd, rd, wr, d, e, lat, rr, p, t);
      expE = 1'b0; expD = 32'h0;
      if (refMisal(op, addr)) begin
        expE = 1'b1; expL = 2;
      end else if (op <= 3'd4) begin
        expL = rd + 2; expD = refLoad(op, addr, refMem[idx]);
      end else if (op == 3'd5) begin
        expL = wr + 2; refMem[idx] = refStore(op, addr, refMem[idx], wd);
      end else begin
        expL = rd + wr + 4; refMem[idx] = refStore(op, addr, refMem[idx], wd);
      end
      checks++; if (d !== expD || e !== expE || lat !== expL) begin failures++; $display("FAIL rnd_resp op=%0d addr=%h got d=%h e=%b lat=%0d exp d=%h e=%b lat=%0d", op, addr, d, e, lat, expD, expE, expL); end
      checks++; if (envMem[idx] !== refMem[idx]) begin failures++; $display("FAIL rnd_mem op=%0d addr=%h got=%h exp=%h", op, addr, envMem[idx], refMem[idx]); end
    end
  endtask

  task automatic test_stability;
    checks++; if (stableViol !== 0) begin failures++; $display("FAIL mem_stable got violations=%0d exp=0", stableViol); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_reset_midflight;
    test_back_to_back;
    test_random;
    test_stability;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
